wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter B, default 32, data width in bits.
REQ-002 Parameter W, default 5, register address width in bits.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising i_clk).
REQ-005 i_stall  input  1  hold MEM/WB latch contents.
REQ-006 i_flush  input  1  load a bubble into the latch.
REQ-007 i_valid_M  input  1  MEM-stage instruction valid.
REQ-008 i_reg_write_M  input  1  RegWrite control from MEM.
REQ-009 i_mem_to_reg_M  input  1  1 = write back load data, 0 = write back ALU result.
REQ-010 i_load_size_M  input  2  00 byte, 01 halfword, 10/11 word.
REQ-011 i_load_unsigned_M  input  1  1 = zero-extend, 0 = sign-extend sub-word loads.
REQ-012 i_byte_off_M  input  2  load address bits [1:0].
REQ-013 i_mem_data_M  input  B  raw word read from data memory.
REQ-014 i_alu_result_M  input  B  ALU result from MEM.
REQ-015 i_write_reg_M  input  W  destination register.
REQ-016 o_reg_write_MC  output  1  RegWrite to register file.
REQ-017 o_write_register  output  W  write address to register file.
REQ-018 o_write_data  output  B  write data to register file (also forwarding source).
REQ-019 o_valid_W  output  1  WB-stage instruction valid.
REQ-020 o_retired  output  32  count of instructions retired.

Function
REQ-021 The block SHALL hold a MEM/WB latch of all *_M inputs plus a valid bit, updated on rising i_clk.
REQ-022 Latch update priority SHALL be: reset > flush > stall > load.
REQ-023 With i_flush=1 the valid bit and latched reg_write SHALL clear; other latched fields are don't-care.
REQ-024 With i_stall=1 and i_flush=0 every latched field SHALL hold.
REQ-025 Otherwise every field SHALL capture its *_M input; latency M-input to WB-output is exactly 1 cycle.
REQ-026 o_write_register and o_valid_W SHALL be the latched destination and valid bit.
REQ-027 o_reg_write_MC SHALL equal valid AND reg_write AND (write_register != 0); register 0 is never written.
REQ-028 o_write_data SHALL be the latched ALU result when mem_to_reg=0, else the extended load value.
REQ-029 Byte load: select mem_data[8*off+7 : 8*off], extend to B bits per unsigned flag.
REQ-030 Halfword load: off[1]=0 selects [15:0], off[1]=1 selects [31:16]; off[0] ignored; extend per unsigned flag.
REQ-031 Word load: full mem_data, unsigned flag and offset ignored.
REQ-032 Output data path SHALL be combinational from the latch only (no combinational path from *_M inputs).
REQ-033 o_retired SHALL increment by 1 on each edge where the latch loads (no reset/flush/stall) with i_valid_M=1.
REQ-034 o_retired SHALL wrap from 32'hFFFFFFFF to 0 without saturation or flag.
REQ-035 Stall and flush cycles SHALL NOT increment o_retired; simultaneous stall+flush acts as flush.

Reset
REQ-036 On i_reset=0 at a rising edge: valid, reg_write, mem_to_reg, all latched data/addresses and o_retired SHALL be 0.
REQ-037 After reset o_reg_write_MC=0, o_write_register=0, o_write_data=0, o_valid_W=0, o_retired=0.
REQ-038 Reset asserted mid-stall or mid-flush SHALL override both in the same cycle.

Verification
REQ-039 ALU writeback: valid=1, reg_write=1, mem_to_reg=0, alu=32'h0000_1234, dst=5 -> next cycle o_reg_write_MC=1, reg 5, data 32'h0000_1234, o_retired=1.
REQ-040 Loads: mem_data=32'h80FF_7F81; byte off=0 signed -> 32'hFFFF_FF81; byte off=1 unsigned -> 32'h0000_007F; half off=2 signed -> 32'hFFFF_80FF; word -> 32'h80FF_7F81.
REQ-041 Register-0 write: reg_write=1, dst=0 -> o_reg_write_MC=0, o_valid_W=1, o_retired increments.
REQ-042 Stall 3 cycles with changing *_M inputs -> outputs unchanged, o_retired unchanged; stall+flush together -> o_valid_W=0, o_reg_write_MC=0.
REQ-043 Preload o_retired near wrap (drive 2 valid loads after reaching 32'hFFFFFFFF) -> sequence FFFFFFFF, 0, 1.
REQ-044 i_reset=0 while latch holds valid write -> next edge all outputs 0; i_reset=1 with i_valid_M=0 -> outputs stay 0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline latch, load extension, retire counter.
// Ports: i_clk/i_reset (sync, active-low), i_stall/i_flush latch control,
//   *_M fields from MEM, regfile write port o_reg_write_MC/o_write_register/
//   o_write_data, o_valid_W and the o_retired instruction count.
module wb_stage #(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_stall,
  input  logic         i_flush,
  input  logic         i_valid_M,
  input  logic         i_reg_write_M,
  input  logic         i_mem_to_reg_M,
  input  logic [1:0]   i_load_size_M,
  input  logic         i_load_unsigned_M,
  input  logic [1:0]   i_byte_off_M,
  input  logic [B-1:0] i_mem_data_M,
  input  logic [B-1:0] i_alu_result_M,
  input  logic [W-1:0] i_write_reg_M,
  output logic         o_reg_write_MC,
  output logic [W-1:0] o_write_register,
  output logic [B-1:0] o_write_data,
  output logic         o_valid_W,
  output logic [31:0]  o_retired
);

  typedef struct packed {
    logic         valid;
    logic         reg_write;
    logic         mem_to_reg;
    logic [1:0]   load_size;
    logic         load_unsigned;
    logic [1:0]   byte_off;
    logic [B-1:0] mem_data;
    logic [B-1:0] alu_result;
    logic [W-1:0] write_reg;
  } mem_wb_t;

  mem_wb_t     wb;
  mem_wb_t     wb_next;
  logic [31:0] retired;
  logic [31:0] retired_next;

  always_comb begin
    wb_next      = wb;
    retired_next = retired;
    if (!i_reset) begin
      wb_next      = '0;
      retired_next = '0;
    end else if (i_flush) begin
      // Bubble: only the fields that can cause a write are cleared.
      wb_next.valid     = 1'b0;
      wb_next.reg_write = 1'b0;
    end else if (!i_stall) begin
      wb_next.valid         = i_valid_M;
      wb_next.reg_write     = i_reg_write_M;
      wb_next.mem_to_reg    = i_mem_to_reg_M;
      wb_next.load_size     = i_load_size_M;
      wb_next.load_unsigned = i_load_unsigned_M;
      wb_next.byte_off      = i_byte_off_M;
      wb_next.mem_data      = i_mem_data_M;
      wb_next.alu_result    = i_alu_result_M;
      wb_next.write_reg     = i_write_reg_M;
      if (i_valid_M) begin
        retired_next = retired + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    wb      <= wb_next;
    retired <= retired_next;
  end

  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [B-1:0] load_val;

  always_comb begin
    byte_sel = wb.mem_data[7:0];
    unique case (wb.byte_off)
      2'd0: byte_sel = wb.mem_data[7:0];
      2'd1: byte_sel = wb.mem_data[15:8];
      2'd2: byte_sel = wb.mem_data[23:16];
      2'd3: byte_sel = wb.mem_data[31:24];
      default: byte_sel = wb.mem_data[7:0];
    endcase
  end

  // Halfword loads are aligned; off[0] plays no part.
  assign half_sel = wb.byte_off[1] ? wb.mem_data[31:16]
                                   : wb.mem_data[15:0];

  always_comb begin
    load_val = wb.mem_data;
    unique case (1'b1)
      (wb.load_size == 2'b00): begin
        if (wb.load_unsigned)
          load_val = {{(B-8){1'b0}}, byte_sel};
        else
          load_val = {{(B-8){byte_sel[7]}}, byte_sel};
      end
      (wb.load_size == 2'b01): begin
        if (wb.load_unsigned)
          load_val = {{(B-16){1'b0}}, half_sel};
        else
          load_val = {{(B-16){half_sel[15]}}, half_sel};
      end
      wb.load_size[1]: load_val = wb.mem_data;
      default: load_val = wb.mem_data;
    endcase
  end

  assign o_write_data     = wb.mem_to_reg ? load_val : wb.alu_result;
  assign o_write_register = wb.write_reg;
  assign o_valid_W        = wb.valid;
  assign o_reg_write_MC   = wb.valid & wb.reg_write & (|wb.write_reg);
  assign o_retired        = retired;

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage.
// Expected outputs are queued at drive time and popped after the edge.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        valid_m;
  logic        rw_m;
  logic        m2r_m;
  logic [1:0]  size_m;
  logic        uns_m;
  logic [1:0]  off_m;
  logic [31:0] mem_m;
  logic [31:0] alu_m;
  logic [4:0]  dst_m;
  logic        reg_write_mc;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        valid_w;
  logic [31:0] retired;

  wb_stage #(.B(32), .W(5)) dut (
    .i_clk             (clk),
    .i_reset           (rst_n),
    .i_stall           (stall),
    .i_flush           (flush),
    .i_valid_M         (valid_m),
    .i_reg_write_M     (rw_m),
    .i_mem_to_reg_M    (m2r_m),
    .i_load_size_M     (size_m),
    .i_load_unsigned_M (uns_m),
    .i_byte_off_M      (off_m),
    .i_mem_data_M      (mem_m),
    .i_alu_result_M    (alu_m),
    .i_write_reg_M     (dst_m),
    .o_reg_write_MC    (reg_write_mc),
    .o_write_register  (write_register),
    .o_write_data      (write_data),
    .o_valid_W         (valid_w),
    .o_retired         (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        full;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        v;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference latch
  logic        m_v, m_rw, m_m2r, m_uns;
  logic [1:0]  m_sz, m_off;
  logic [31:0] m_mem, m_alu, m_ret;
  logic [4:0]  m_dst;

  function automatic logic [31:0] ext(input logic [1:0] sz,
                                      input logic uns,
                                      input logic [1:0] off,
                                      input logic [31:0] mem);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(mem >> (8 * off));
    h = off[1] ? mem[31:16] : mem[15:0];
    if (sz == 2'b00)
      return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01)
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return mem;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic fl,
                      input logic v, input logic rw, input logic m2r,
                      input logic [1:0] sz, input logic uns,
                      input logic [1:0] off, input logic [31:0] mem,
                      input logic [31:0] alu, input logic [4:0] dst);
    exp_t e;
    @(negedge clk);
    rst_n = r; stall = st; flush = fl;
    valid_m = v; rw_m = rw; m2r_m = m2r;
    size_m = sz; uns_m = uns; off_m = off;
    mem_m = mem; alu_m = alu; dst_m = dst;
    e.full = 1'b1;
    if (!r) begin
      m_v = 0; m_rw = 0; m_m2r = 0; m_uns = 0;
      m_sz = 0; m_off = 0; m_mem = 0; m_alu = 0;
      m_dst = 0; m_ret = 0;
    end else if (fl) begin
      m_v = 0; m_rw = 0;
      e.full = 1'b0;
    end else if (!st) begin
      m_v = v; m_rw = rw; m_m2r = m2r; m_uns = uns;
      m_sz = sz; m_off = off; m_mem = mem; m_alu = alu;
      m_dst = dst;
      if (v) m_ret = m_ret + 32'd1;
    end
    e.v   = m_v;
    e.wr  = m_dst;
    e.rw  = m_v & m_rw & (m_dst != 5'd0);
    e.wd  = m_m2r ? ext(m_sz, m_uns, m_off, m_mem) : m_alu;
    e.ret = m_ret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("valid_w", {31'd0, valid_w}, {31'd0, e.v});
    chk("reg_write_mc", {31'd0, reg_write_mc}, {31'd0, e.rw});
    chk("retired", retired, e.ret);
    if (e.full) begin
      chk("write_register", {27'd0, write_register}, {27'd0, e.wr});
      chk("write_data", write_data, e.wd);
    end
  endtask

  localparam logic [31:0] MD = 32'h80FF_7F81;

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    valid_m = 0; rw_m = 0; m2r_m = 0;
    size_m = 0; uns_m = 0; off_m = 0;
    mem_m = 0; alu_m = 0; dst_m = 0;

    // reset state
    step(0, 0, 0, 1, 1, 0, 2'b10, 0, 0, MD, 32'h55, 5'd3);
    chk("rst_data", write_data, 32'h0);

    // ALU writeback
    step(1, 0, 0, 1, 1, 0, 2'b10, 0, 0, MD, 32'h0000_1234, 5'd5);
    chk("alu_lit_data", write_data, 32'h0000_1234);
    chk("alu_lit_ret", retired, 32'd1);

    // loads
    step(1, 0, 0, 1, 1, 1, 2'b00, 0, 2'd0, MD, 32'h0, 5'd7);
    chk("lb_off0", write_data, 32'hFFFF_FF81);
    step(1, 0, 0, 1, 1, 1, 2'b00, 1, 2'd1, MD, 32'h0, 5'd7);
    chk("lbu_off1", write_data, 32'h0000_007F);
    step(1, 0, 0, 1, 1, 1, 2'b01, 0, 2'd2, MD, 32'h0, 5'd7);
    chk("lh_off2", write_data, 32'hFFFF_80FF);
    step(1, 0, 0, 1, 1, 1, 2'b10, 1, 2'd3, MD, 32'h0, 5'd7);
    chk("lw", write_data, MD);
    step(1, 0, 0, 1, 1, 1, 2'b01, 1, 2'd1, MD, 32'h0, 5'd8);
    step(1, 0, 0, 1, 1, 1, 2'b00, 0, 2'd3, MD, 32'h0, 5'd9);
    step(1, 0, 0, 1, 1, 1, 2'b11, 0, 2'd1, MD, 32'h0, 5'd9);

    // register 0 never written
    step(1, 0, 0, 1, 1, 0, 2'b10, 0, 0, MD, 32'hDEAD, 5'd0);
    chk("r0_rw", {31'd0, reg_write_mc}, 32'd0);

    // stall for 3 cycles with changing inputs
    step(1, 0, 0, 1, 1, 0, 2'b10, 0, 0, MD, 32'hCAFE, 5'd12);
    step(1, 1, 0, 1, 1, 0, 2'b10, 0, 0, MD, 32'h1111, 5'd13);
    step(1, 1, 0, 0, 0, 1, 2'b00, 1, 1, 32'h1, 32'h2222, 5'd14);
    step(1, 1, 0, 1, 1, 1, 2'b01, 0, 2, 32'h2, 32'h3333, 5'd15);
    chk("stall_hold", write_data, 32'hCAFE);
    // stall + flush acts as flush
    step(1, 1, 1, 1, 1, 0, 2'b10, 0, 0, MD, 32'h4444, 5'd16);
    step(1, 0, 1, 1, 1, 0, 2'b10, 0, 0, MD, 32'h5555, 5'd17);
    step(1, 0, 0, 0, 1, 0, 2'b10, 0, 0, MD, 32'h6666, 5'd18);

    // counter wrap
    @(negedge clk);
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    m_ret = 32'hFFFF_FFFF;
    #1;
    chk("wrap_pre", retired, 32'hFFFF_FFFF);
    step(1, 0, 0, 1, 1, 0, 2'b10, 0, 0, MD, 32'hA, 5'd1);
    chk("wrap_0", retired, 32'h0);
    step(1, 0, 0, 1, 1, 0, 2'b10, 0, 0, MD, 32'hB, 5'd2);
    chk("wrap_1", retired, 32'h1);

    // reset over a valid write, with stall and flush raised
    step(1, 0, 0, 1, 1, 0, 2'b10, 0, 0, MD, 32'hC, 5'd4);
    step(0, 1, 1, 1, 1, 0, 2'b10, 0, 0, MD, 32'hD, 5'd6);
    chk("rst_ovr_ret", retired, 32'h0);
    step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 5'd0);
    chk("post_rst_data", write_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
